// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the minuteCore fetch front end.
// Provides address/instruction widths, the fetch FSM state type, the FIFO
// entry layout and a saturating increment used by the optional counters.
package fetch_stage_pkg;

  localparam int unsigned ADDR_SIZE  = 31;
  localparam int unsigned INSTR_SIZE = 31;
  localparam int unsigned AW         = ADDR_SIZE + 1;
  localparam int unsigned IW         = INSTR_SIZE + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries for the fetch stage.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, wdata       write an entry (accepted when not full, or full with pop)
//   pop               remove the head entry (ignored when empty)
//   flush             discard all entries; wins over push and pop
//   rdata             head entry, combinational
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  // Full plus pop frees the head slot in the same edge, so the write is safe.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; the head is only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues one imem read at a time,
// buffers returned words and hands {pc, instr} to decode over valid/ready.
// Redirects flush the buffer and retarget the PC; a response belonging to the
// flushed path is discarded.
// Optional feature: define FETCH_PERF_CNT_EN to add saturating perf counters.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   imem_rd_addr/enable             read request, held until imem_rd_ready
//   imem_rd_data/ready              one-cycle response strobe with data
//   redirect_valid/pc               taken branch/jump target from execute
//   dec_valid/ready/pc/instr        FIFO head towards decode
//   perf_fetch_cnt, perf_stall_cnt  words pushed / decode-starved cycles
//                                   (FETCH_PERF_CNT_EN only)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [AW-1:0] RESET_PC   = '0,
  parameter int unsigned   FIFO_DEPTH = 4,
  parameter int unsigned   PC_STEP    = 4
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_rd_addr,
  output logic          imem_rd_enable,
  input  logic [IW-1:0] imem_rd_data,
  input  logic          imem_rd_ready,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [AW-1:0] dec_pc,
  output logic [IW-1:0] dec_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e  st_q, st_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          en_q, en_d;
  logic          push, pop;
  logic          full, empty;
  logic [CW-1:0] count;
  fetch_entry_t  head;

  always_comb begin
    st_d   = st_q;
    pc_d   = pc_q;
    addr_d = addr_q;
    en_d   = en_q;
    push   = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (count < CW'(FIFO_DEPTH)) begin
          // Nothing is in flight in idle, so one free slot covers the next word.
          st_d   = StReq;
          en_d   = 1'b1;
          addr_d = pc_q;
        end
      end
      StReq: begin
        if (imem_rd_ready) begin
          st_d = StIdle;
          en_d = 1'b0;
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else begin
            push = ~full;
            pc_d = pc_q + AW'(PC_STEP);
          end
        end else if (redirect_valid) begin
          st_d = StDrop;
          pc_d = redirect_pc;
        end
      end
      StDrop: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_rd_ready) begin
          st_d = StIdle;
          en_d = 1'b0;
        end
      end
      default: begin
        st_d = StIdle;
        en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= StIdle;
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
      en_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      pc_q   <= pc_d;
      addr_q <= addr_d;
      en_q   <= en_d;
    end
  end

  // A redirect flushes the FIFO and suppresses the same-cycle pop.
  assign pop = ~empty & dec_ready & ~redirect_valid;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AW + IW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({addr_q, imem_rd_data}),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign imem_rd_addr   = addr_q;
  assign imem_rd_enable = en_q;
  assign dec_valid      = ~empty;
  assign dec_pc         = empty ? '0 : head.pc;
  assign dec_instr      = empty ? '0 : head.instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push)                  fetch_cnt_q <= sat_inc(fetch_cnt_q);
      if (dec_ready && empty)    stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: imem model with fixed or random latency,
// a queue of expected {pc, instr} derived from the sequential-fetch/redirect
// rules, and a monitor that checks each accepted decode transfer.
// Honours FETCH_PERF_CNT_EN when defined.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned STEP     = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_rd_addr;
  logic        imem_rd_enable;
  logic [31:0] imem_rd_data;
  logic        imem_rd_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_stage #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH),
    .PC_STEP    (STEP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_rd_addr   (imem_rd_addr),
    .imem_rd_enable (imem_rd_enable),
    .imem_rd_data   (imem_rd_data),
    .imem_rd_ready  (imem_rd_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_instr      (dec_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference stream: decode must see consecutive words from the last restart.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_pc;

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back({next_pc, mem_word(next_pc)});
      next_pc = next_pc + STEP;
    end
  endtask

  task automatic model_restart(input logic [31:0] target);
    exp_q.delete();
    next_pc = target;
    top_up();
  endtask

  // Monitor: one accepted transfer per negedge at most.
  int pop_cnt   = 0;
  int stall_cnt = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b0) begin
      if (dec_ready && !dec_valid) stall_cnt++;
      if (dec_valid && dec_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          vec++;
          errs++;
          $display("FAIL scoreboard_empty: got pc %h, expected no transfer", dec_pc);
        end else begin
          e = exp_q.pop_front();
          check("dec_pc", dec_pc, e.pc);
          check("dec_instr", dec_instr, e.instr);
          pop_cnt++;
        end
      end
    end
  end

  // imem model: captures a request, answers after lat cycles with a 1-cycle strobe.
  logic        imem_hold = 1'b0;
  int          lat_fixed = 1;
  logic        busy      = 1'b0;
  int          lat_cnt   = 0;
  logic [31:0] cap_addr  = '0;
  logic [31:0] cap_q[$];
  int          resp_cnt  = 0;

  initial begin
    imem_rd_ready = 1'b0;
    imem_rd_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        busy          = 1'b0;
        imem_rd_ready = 1'b0;
      end else if (imem_rd_ready) begin
        imem_rd_ready = 1'b0;
        busy          = 1'b0;
        resp_cnt++;
        check("en_drop_after_ready", {31'd0, imem_rd_enable}, 32'd0);
      end else if (busy) begin
        check("addr_hold", imem_rd_addr, cap_addr);
        check("en_hold", {31'd0, imem_rd_enable}, 32'd1);
        if (!imem_hold) begin
          if (lat_cnt == 0) begin
            imem_rd_ready = 1'b1;
            imem_rd_data  = mem_word(cap_addr);
          end else begin
            lat_cnt--;
          end
        end
      end else if (imem_rd_enable) begin
        busy     = 1'b1;
        cap_addr = imem_rd_addr;
        cap_q.push_back(imem_rd_addr);
        lat_cnt  = ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3))) - 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    top_up();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    model_restart(RESET_PC);
    cap_q.delete();
    resp_cnt  = 0;
    stall_cnt = 0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic wait_pops(input int n);
    int s;
    int k;
    s = pop_cnt;
    k = 0;
    while ((pop_cnt - s) < n && k < 300) begin
      cyc();
      k++;
    end
    check("pop_progress", ((pop_cnt - s) >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_cap(input string name, input logic [31:0] exp_addr);
    int k;
    k = 0;
    while (cap_q.size() == 0 && k < 100) begin
      cyc();
      k++;
    end
    check(name, (cap_q.size() > 0) ? cap_q[0] : 32'hDEAD_BEEF, exp_addr);
  endtask

  task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_cnt", perf_fetch_cnt, resp_cnt);
    check("perf_stall_cnt", perf_stall_cnt, stall_cnt);
`endif
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : driver
    int          k;
    logic [31:0] a;
    logic [31:0] tgt;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    next_pc        = RESET_PC;

    // Reset state.
    #2;
    check("rst_en", {31'd0, imem_rd_enable}, 32'd0);
    check("rst_addr", imem_rd_addr, RESET_PC);
    check("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_dec_pc", dec_pc, 32'd0);
    check("rst_dec_instr", dec_instr, 32'd0);

    // Sequential fetch, latency 1, decode always ready.
    lat_fixed = 1;
    dec_ready = 1'b1;
    do_reset();
    wait_pops(12);
    for (int i = 0; i < 8; i++) begin
      a = (cap_q.size() > i) ? cap_q[i] : 32'hDEAD_BEEF;
      check("seq_issue_addr", a, RESET_PC + i * STEP);
    end
    check_perf();

    // Decode stalled: FIFO fills to DEPTH, then no more requests.
    dec_ready = 1'b0;
    do_reset();
    repeat (40) cyc();
    check("buffered_words", resp_cnt, DEPTH);
    check("en_when_full", {31'd0, imem_rd_enable}, 32'd0);
    check("valid_when_full", {31'd0, dec_valid}, 32'd1);
    check_perf();
    cap_q.delete();
    dec_ready = 1'b1;
    wait_cap("resume_addr", RESET_PC + DEPTH * STEP);
    wait_pops(8);

    // Redirect while the request for 0x8 is outstanding.
    lat_fixed = 3;
    do_reset();
    k = 0;
    while (!(imem_rd_enable && imem_rd_addr == 32'h8 && !imem_rd_ready) && k < 100) begin
      cyc();
      k++;
    end
    check("req8_seen", imem_rd_addr, 32'h8);
    imem_hold      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    model_restart(32'h100);
    cap_q.delete();
    cyc();
    redirect_valid = 1'b0;
    imem_hold      = 1'b0;
    check("valid_after_redirect", {31'd0, dec_valid}, 32'd0);
    wait_cap("addr_after_drop", 32'h100);
    wait_pops(6);

    // Redirect coinciding with an imem response and a decode pop.
    lat_fixed = 0;
    dec_ready = 1'b0;
    k = 0;
    while (!(imem_rd_ready && dec_valid) && k < 100) begin
      cyc();
      k++;
    end
    check("coincide_seen", {31'd0, imem_rd_ready & dec_valid}, 32'd1);
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    model_restart(32'h200);
    cap_q.delete();
    cyc();
    redirect_valid = 1'b0;
    check("flush_empty", {31'd0, dec_valid}, 32'd0);
    wait_cap("addr_after_coincide", 32'h200);
    wait_pops(6);

    // Reset asserted while a request is outstanding.
    k = 0;
    while (!(imem_rd_enable && !imem_rd_ready) && k < 100) begin
      cyc();
      k++;
    end
    reset = 1'b1;
    model_restart(RESET_PC);
    #3;
    check("midrst_en", {31'd0, imem_rd_enable}, 32'd0);
    check("midrst_addr", imem_rd_addr, RESET_PC);
    check("midrst_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("midrst_dec_pc", dec_pc, 32'd0);
    check("midrst_dec_instr", dec_instr, 32'd0);
    cap_q.delete();
    resp_cnt  = 0;
    stall_cnt = 0;
    repeat (2) cyc();
    reset = 1'b0;
    wait_cap("addr_after_reset", RESET_PC);
    wait_pops(6);

    // Random traffic: decode back-pressure, latency and redirects incl. wrap.
    for (int i = 0; i < 500; i++) begin
      cyc();
      dec_ready = ($urandom_range(0, 3) != 0);
      if (redirect_valid) begin
        redirect_valid = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        tgt = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'h0000_FFFC);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        model_restart(tgt);
      end
    end
    cyc();
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    wait_pops(6);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
